// File: rtl/pe_pkg.sv
// Shared PE-array constants and types for the weight-ROM arbiter and the future output-buffer arbiters.
// Pure declarations: no logic, no latency, no flow control.
package pe_pkg;

   localparam int unsigned PE_ROM_LATENCY = 2;
   localparam int unsigned PE_BURST_LEN   = 9;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

   // Counter width that never collapses to zero bits for a modulus of 1.
   function automatic int unsigned pe_cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_weight_rom_arbiter_if.sv
// Request, ROM and response signals between the PE controllers, the weight ROM and the arbiter.
// slave = arbiter view; master = requester/ROM environment view.
interface pe_weight_rom_arbiter_if #(
   parameter int unsigned pREQ_NUM    = 4,
   parameter int unsigned pADDR_WIDTH = 10,
   parameter int unsigned pDATA_WIDTH = 256
);

   logic [pREQ_NUM-1:0]             req;
   logic [pREQ_NUM*pADDR_WIDTH-1:0] req_addr;
   logic [pREQ_NUM-1:0]             gnt;
   logic                            rom_en;
   logic [pADDR_WIDTH-1:0]          rom_addr;
   logic [pDATA_WIDTH-1:0]          rom_data;
   logic [pREQ_NUM-1:0]             rsp_valid;
   logic [pDATA_WIDTH-1:0]          rsp_data;
   logic                            busy;

   modport slave (
      input  req,
      input  req_addr,
      input  rom_data,
      output gnt,
      output rom_en,
      output rom_addr,
      output rsp_valid,
      output rsp_data,
      output busy
   );

   modport master (
      output req,
      output req_addr,
      output rom_data,
      input  gnt,
      input  rom_en,
      input  rom_addr,
      input  rsp_valid,
      input  rsp_data,
      input  busy
   );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set req bit scanning upward from ptr_i, wrapping modulo N.
// Zero latency; no flow control of its own.
module rr_priority_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  onehot_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   logic found;

   always_comb begin
      found    = 1'b0;
      onehot_o = '0;
      idx_o    = '0;
      // k is the scan distance from ptr_i; the first hit along that order wins.
      for (int k = 0; k < int'(N); k++) begin
         for (int m = 0; m < int'(N); m++) begin
            if (!found && req_i[m] && (((int'(ptr_i) + k) % int'(N)) == m)) begin
               found       = 1'b1;
               onehot_o[m] = 1'b1;
               idx_o       = PW'(m);
            end
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/pe_weight_rom_arbiter.sv
// Round-robin sharing of one weight ROM among PE controllers in fixed bursts of pBURST_LEN beats.
// One cycle of arbitration from IDLE, back-to-back bursts after that; responses return pROM_LATENCY cycles after issue.
module pe_weight_rom_arbiter
   import pe_pkg::*;
#(
   parameter int unsigned pREQ_NUM     = 4,
   parameter int unsigned pADDR_WIDTH  = 10,
   parameter int unsigned pDATA_WIDTH  = 256,
   parameter int unsigned pBURST_LEN   = PE_BURST_LEN,
   parameter int unsigned pROM_LATENCY = PE_ROM_LATENCY
) (
   input logic                   clk,
   input logic                   rst,
   pe_weight_rom_arbiter_if.slave bus
);

   localparam int unsigned PW = $clog2(pREQ_NUM);
   localparam int unsigned BW = pe_cnt_w(pBURST_LEN);

   localparam logic [0:0]    ST_IDLE   = ARB_IDLE;
   localparam logic [0:0]    ST_BURST  = ARB_BURST;
   localparam logic [BW-1:0] LAST_BEAT = BW'(pBURST_LEN - 1);
   localparam logic [PW-1:0] LAST_IDX  = PW'(pREQ_NUM - 1);

   logic [0:0]             state_q, state_d;
   logic [pREQ_NUM-1:0]    gnt_q, gnt_d;
   logic [PW-1:0]          win_q, win_d;
   logic [PW-1:0]          rr_q, rr_d;
   logic [BW-1:0]          beat_q, beat_d;

   logic [PW-1:0]          ptr_next;
   logic [PW-1:0]          pick_ptr;
   logic [pREQ_NUM-1:0]    pick_oh;
   logic [PW-1:0]          pick_idx;
   logic                   pick_any;

   logic                   in_burst;
   logic                   last_beat;
   logic                   win_req;
   logic                   burst_end;
   logic                   rom_en;
   logic [pADDR_WIDTH-1:0] win_addr;
   logic [pDATA_WIDTH-1:0] rsp_data;

   logic [pROM_LATENCY-1:0] tag_vld_q;
   logic [pREQ_NUM-1:0]     tag_id_q [pROM_LATENCY];

   always_comb begin
      win_req  = 1'b0;
      win_addr = '0;
      for (int k = 0; k < int'(pREQ_NUM); k++) begin
         if (win_q == PW'(k)) begin
            win_req  = bus.req[k];
            win_addr = bus.req_addr[k*pADDR_WIDTH +: pADDR_WIDTH];
         end
      end
   end

   assign in_burst  = (state_q == ST_BURST);
   assign last_beat = (beat_q == LAST_BEAT);

   // A drop on the final beat is the requester releasing at completion, not an abort.
   assign rom_en    = in_burst && (win_req || last_beat);
   assign burst_end = in_burst && (last_beat || !win_req);

   assign ptr_next = (win_q == LAST_IDX) ? '0 : win_q + PW'(1);
   assign pick_ptr = in_burst ? ptr_next : rr_q;

   rr_priority_picker #(
      .N  (pREQ_NUM),
      .PW (PW)
   ) u_picker (
      .req_i    (bus.req),
      .ptr_i    (pick_ptr),
      .onehot_o (pick_oh),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      win_d   = win_q;
      rr_d    = rr_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d = ST_BURST;
               gnt_d   = pick_oh;
               win_d   = pick_idx;
               beat_d  = '0;
            end
         end
         default: begin
            if (burst_end) begin
               rr_d   = ptr_next;
               beat_d = '0;
               if (pick_any) begin
                  gnt_d = pick_oh;
                  win_d = pick_idx;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         win_q   <= '0;
         rr_q    <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         win_q   <= win_d;
         rr_q    <= rr_d;
         beat_q  <= beat_d;
      end
   end

   // Tag pipe mirrors the ROM latency so each data beat carries its owner's id.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld_q <= '0;
         for (int s = 0; s < int'(pROM_LATENCY); s++) begin
            tag_id_q[s] <= '0;
         end
      end else begin
         tag_vld_q[0] <= rom_en;
         tag_id_q[0]  <= gnt_q;
         for (int s = 1; s < int'(pROM_LATENCY); s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
         end
      end
   end

   assign rsp_data      = bus.rom_data;

   assign bus.gnt       = gnt_q;
   assign bus.rom_en    = rom_en;
   assign bus.rom_addr  = in_burst ? win_addr : '0;
   assign bus.rsp_valid = tag_vld_q[pROM_LATENCY-1] ? tag_id_q[pROM_LATENCY-1] : '0;
   assign bus.rsp_data  = rsp_data;
   assign bus.busy      = in_burst || (|tag_vld_q);

endmodule
